// File: rtl/pattern_window_ctrl.sv
// Measurement-window controller: sequences clear/run/capture windows for one pattern detector
// and hands each captured count to a consumer over valid/ready. Optional THRESH_ALARM_EN adds a threshold alarm.
module pattern_window_ctrl #(
  parameter int CNT_W = 16,
  parameter int WIN_W = 10,
  parameter int PAT_W = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             cfg_we,
  input  logic [PAT_W-1:0] cfg_pattern,
  input  logic [WIN_W-1:0] cfg_window,
  input  logic             cfg_cont,
`ifdef THRESH_ALARM_EN
  input  logic [CNT_W-1:0] cfg_thresh,
  output logic             alarm,
`endif
  input  logic             start,
  input  logic             stop,
  input  logic [CNT_W-1:0] det_count,
  output logic             det_clear,
  output logic             det_en,
  output logic [PAT_W-1:0] det_pattern,
  output logic [CNT_W-1:0] res_data,
  output logic             res_valid,
  input  logic             res_ready,
  output logic             res_lost,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, CLEAR, RUN, CAPTURE} state_t;

  state_t           state;
  logic [WIN_W-1:0] window_len;
  logic [WIN_W-1:0] win_cnt;
  logic             cont;
`ifdef THRESH_ALARM_EN
  logic [CNT_W-1:0] thresh;
`endif

  // Outputs are set alongside each transition so they are registered copies of the next state.
  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      window_len  <= WIN_W'(1000);
      win_cnt     <= '0;
      cont        <= 1'b0;
      det_pattern <= PAT_W'(16'hAFAF);
      det_clear   <= 1'b0;
      det_en      <= 1'b0;
      res_data    <= '0;
      res_valid   <= 1'b0;
      res_lost    <= 1'b0;
      busy        <= 1'b0;
`ifdef THRESH_ALARM_EN
      thresh      <= '1;
      alarm       <= 1'b0;
`endif
    end else begin
      det_clear <= 1'b0;
      if (res_valid && res_ready) begin
        res_valid <= 1'b0;
`ifdef THRESH_ALARM_EN
        alarm     <= 1'b0;
`endif
      end
      case (state)
        IDLE: begin
          if (cfg_we && cfg_window != '0) begin
            det_pattern <= cfg_pattern;
            window_len  <= cfg_window;
            cont        <= cfg_cont;
`ifdef THRESH_ALARM_EN
            thresh      <= cfg_thresh;
`endif
          end
          if (start && !stop) begin
            state     <= CLEAR;
            det_clear <= 1'b1;
            busy      <= 1'b1;
            res_lost  <= 1'b0;
          end
        end
        CLEAR: begin
          win_cnt <= '0;
          if (stop) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            state  <= RUN;
            det_en <= 1'b1;
          end
        end
        RUN: begin
          if (stop) begin
            state  <= IDLE;
            det_en <= 1'b0;
            busy   <= 1'b0;
          end else if (win_cnt == window_len - WIN_W'(1)) begin
            state  <= CAPTURE;
            det_en <= 1'b0;
          end else begin
            win_cnt <= win_cnt + WIN_W'(1);
          end
        end
        CAPTURE: begin
          // A slot being drained this cycle counts as free, so back-to-back results never collide.
          if (!res_valid || res_ready) begin
            res_data  <= det_count;
            res_valid <= 1'b1;
`ifdef THRESH_ALARM_EN
            alarm     <= (det_count >= thresh);
`endif
          end else begin
            res_lost <= 1'b1;
          end
          if (cont && !stop) begin
            state     <= CLEAR;
            det_clear <= 1'b1;
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pattern_window_ctrl.sv
// Self-checking bench for pattern_window_ctrl: directed steps plus random traffic against
// a window-position reference model. Define THRESH_ALARM_EN to also exercise the alarm.
module tb_pattern_window_ctrl;
  localparam int CNT_W = 16;
  localparam int WIN_W = 10;
  localparam int PAT_W = 16;

  logic             clock = 1'b0;
  logic             reset;
  logic             cfg_we;
  logic [PAT_W-1:0] cfg_pattern;
  logic [WIN_W-1:0] cfg_window;
  logic             cfg_cont;
  logic             start;
  logic             stop;
  logic [CNT_W-1:0] det_count;
  logic             det_clear;
  logic             det_en;
  logic [PAT_W-1:0] det_pattern;
  logic [CNT_W-1:0] res_data;
  logic             res_valid;
  logic             res_ready;
  logic             res_lost;
  logic             busy;
`ifdef THRESH_ALARM_EN
  logic [CNT_W-1:0] cfg_thresh;
  logic             alarm;
`endif

  int testCount = 0;
  int failCount = 0;

  // Reference model: whether a measurement is active, and the 1-based position inside the
  // current window (1 = clear cycle, 2..N+1 = enabled cycles, N+2 = capture cycle).
  bit               mActive;
  int               mT;
  int               mN;
  bit               mCont;
  logic [PAT_W-1:0] mPat;
  bit               mValid;
  logic [CNT_W-1:0] mData;
  bit               mLost;
  logic [CNT_W-1:0] mThresh;
  bit               mAlarm;

  pattern_window_ctrl #(.CNT_W(CNT_W), .WIN_W(WIN_W), .PAT_W(PAT_W)) dut (
    .clock      (clock),
    .reset      (reset),
    .cfg_we     (cfg_we),
    .cfg_pattern(cfg_pattern),
    .cfg_window (cfg_window),
    .cfg_cont   (cfg_cont),
`ifdef THRESH_ALARM_EN
    .cfg_thresh (cfg_thresh),
    .alarm      (alarm),
`endif
    .start      (start),
    .stop       (stop),
    .det_count  (det_count),
    .det_clear  (det_clear),
    .det_en     (det_en),
    .det_pattern(det_pattern),
    .res_data   (res_data),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_lost   (res_lost),
    .busy       (busy)
  );

  always #5 clock = ~clock;

  task automatic modelStep();
    bit xfer;
    bit load;
    xfer = mValid && res_ready;
    load = 1'b0;
    if (reset) begin
      mActive = 0; mT = 0; mN = 1000; mCont = 0; mPat = 16'hAFAF;
      mValid = 0; mData = '0; mLost = 0; mThresh = '1; mAlarm = 0;
      return;
    end
    if (!mActive) begin
      if (cfg_we && cfg_window != 0) begin
        mPat = cfg_pattern; mN = int'(cfg_window); mCont = cfg_cont;
`ifdef THRESH_ALARM_EN
        mThresh = cfg_thresh;
`endif
      end
      if (start && !stop) begin
        mActive = 1; mT = 1; mLost = 0;
      end
    end else if (mT == mN + 2) begin
      if (!mValid || res_ready) begin
        load = 1'b1; mData = det_count; mAlarm = (det_count >= mThresh);
      end else begin
        mLost = 1;
      end
      if (mCont && !stop) mT = 1;
      else mActive = 0;
    end else if (stop) begin
      mActive = 0;
    end else begin
      mT++;
    end
    if (load) mValid = 1;
    else if (xfer) begin
      mValid = 0; mAlarm = 0;
    end
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    testCount++;
    assert (obs === exp) else begin
      failCount++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic checkAll();
    checkOutput("det_clear", 32'(det_clear), 32'(mActive && mT == 1));
    checkOutput("det_en", 32'(det_en), 32'(mActive && mT >= 2 && mT <= mN + 1));
    checkOutput("busy", 32'(busy), 32'(mActive));
    checkOutput("det_pattern", 32'(det_pattern), 32'(mPat));
    checkOutput("res_valid", 32'(res_valid), 32'(mValid));
    checkOutput("res_data", 32'(res_data), 32'(mData));
    checkOutput("res_lost", 32'(res_lost), 32'(mLost));
`ifdef THRESH_ALARM_EN
    if (mValid) checkOutput("alarm", 32'(alarm), 32'(mAlarm));
`endif
  endtask

  // Inputs stay as set by the caller across the edge; outputs are checked on the falling edge.
  task automatic applyStimulus(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(posedge clock);
      modelStep();
      @(negedge clock);
      checkAll();
    end
  endtask

  task automatic idleInputs();
    reset = 0; cfg_we = 0; cfg_pattern = '0; cfg_window = '0; cfg_cont = 0;
    start = 0; stop = 0; det_count = '0; res_ready = 0;
`ifdef THRESH_ALARM_EN
    cfg_thresh = '0;
`endif
  endtask

  task automatic configure(input logic [PAT_W-1:0] pat, input int win, input bit c, input int th);
    cfg_we = 1; cfg_pattern = pat; cfg_window = WIN_W'(win); cfg_cont = c;
`ifdef THRESH_ALARM_EN
    cfg_thresh = CNT_W'(th);
`endif
    applyStimulus(1);
    cfg_we = 0;
  endtask

  task automatic startRun();
    start = 1;
    applyStimulus(1);
    start = 0;
  endtask

  task automatic waitPos(input string tag, input int target, input int bound);
    bit reached;
    reached = 0;
    for (int i = 0; i < bound && !reached; i++) begin
      if (mActive && mT == target) reached = 1;
      else applyStimulus(1);
    end
    checkOutput(tag, 32'(reached), 32'd1);
  endtask

  initial begin
    int enCnt;
    int validAt;
    idleInputs();
    reset = 1;
    applyStimulus(2);
    reset = 0;
    applyStimulus(1);
    checkOutput("reset_pattern", 32'(det_pattern), 32'h0000AFAF);

    // Default window of 1000 cycles, detector count 7 at capture.
    det_count = 16'd7;
    startRun();
    enCnt = 0; validAt = -1;
    for (int k = 1; k <= 1100 && validAt < 0; k++) begin
      if (det_en) enCnt++;
      applyStimulus(1);
      if (res_valid) validAt = k + 1;
    end
    checkOutput("default_en_cycles", 32'(enCnt), 32'd1000);
    checkOutput("default_valid_cycle", 32'(validAt), 32'd1003);
    checkOutput("default_res_data", 32'(res_data), 32'd7);
    checkOutput("default_busy_after", 32'(busy), 32'd0);
    res_ready = 1;
    applyStimulus(1);
    res_ready = 0;

    // Zero-length window write is ignored; then pattern 0x1234 with a 3-cycle window.
    configure(16'h5555, 0, 1, 0);
    checkOutput("zero_win_pattern", 32'(det_pattern), 32'h0000AFAF);
    configure(16'h1234, 3, 0, 5);
    checkOutput("cfg_pattern", 32'(det_pattern), 32'h00001234);
    det_count = 16'd3;
    startRun();
    enCnt = 0;
    for (int k = 0; k < 8; k++) begin
      if (det_en) enCnt++;
      applyStimulus(1);
    end
    checkOutput("win3_en_cycles", 32'(enCnt), 32'd3);
    res_ready = 1;
    applyStimulus(1);
    res_ready = 0;

    // Continuous, window 4, consumer stalled: second capture is dropped.
    configure(16'hBEEF, 4, 1, 5);
    det_count = 16'd11;
    startRun();
    waitPos("cont_first_capture", 6, 20);
    applyStimulus(1);
    det_count = 16'd22;
    waitPos("cont_second_capture", 6, 20);
    applyStimulus(1);
    checkOutput("lost_set", 32'(res_lost), 32'd1);
    checkOutput("lost_data_kept", 32'(res_data), 32'd11);
    stop = 1;
    applyStimulus(2);
    stop = 0;
    startRun();
    checkOutput("lost_cleared", 32'(res_lost), 32'd0);

    // Ready pulsed exactly in the capture cycle: reload without loss.
    det_count = 16'd33;
    waitPos("cont_ready_capture", 6, 20);
    res_ready = 1;
    applyStimulus(1);
    res_ready = 0;
    checkOutput("reload_valid", 32'(res_valid), 32'd1);
    checkOutput("reload_data", 32'(res_data), 32'd33);
    checkOutput("reload_lost", 32'(res_lost), 32'd0);
    stop = 1;
    applyStimulus(3);
    stop = 0;
    res_ready = 1;
    applyStimulus(1);
    res_ready = 0;

    // Stop on the second enabled cycle, then stop+start together in idle.
    configure(16'h0F0F, 4, 0, 5);
    startRun();
    waitPos("reach_run2", 3, 10);
    stop = 1;
    applyStimulus(1);
    stop = 0;
    checkOutput("stop_en", 32'(det_en), 32'd0);
    checkOutput("stop_busy", 32'(busy), 32'd0);
    applyStimulus(8);
    checkOutput("stop_no_result", 32'(res_valid), 32'd0);
    start = 1; stop = 1;
    applyStimulus(1);
    start = 0; stop = 0;
    checkOutput("stop_start_idle", 32'(busy), 32'd0);

    // Reset in the middle of a window.
    startRun();
    applyStimulus(3);
    reset = 1;
    applyStimulus(1);
    reset = 0;
    applyStimulus(2);

`ifdef THRESH_ALARM_EN
    // Threshold 5: count 4 gives no alarm, count 5 does.
    configure(16'h1111, 2, 0, 5);
    res_ready = 1;
    det_count = 16'd4;
    startRun();
    waitPos("alarm_cap1", 4, 10);
    applyStimulus(1);
    checkOutput("alarm_below", 32'(alarm), 32'd0);
    det_count = 16'd5;
    applyStimulus(1);
    startRun();
    waitPos("alarm_cap2", 4, 10);
    applyStimulus(1);
    checkOutput("alarm_at", 32'(alarm), 32'd1);
    res_ready = 0;
    applyStimulus(1);
`endif

    // Random traffic against the model.
    for (int k = 0; k < 600; k++) begin
      cfg_we      = ($urandom_range(0, 9) == 0);
      cfg_pattern = PAT_W'($urandom);
      cfg_window  = WIN_W'($urandom_range(0, 6));
      cfg_cont    = 1'($urandom_range(0, 1));
      start       = ($urandom_range(0, 5) == 0);
      stop        = ($urandom_range(0, 24) == 0);
      res_ready   = 1'($urandom_range(0, 1));
      det_count   = CNT_W'($urandom_range(0, 15));
      reset       = ($urandom_range(0, 199) == 0);
`ifdef THRESH_ALARM_EN
      cfg_thresh  = CNT_W'($urandom_range(0, 15));
`endif
      applyStimulus(1);
    end

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end
endmodule
